serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 167 ++++++++++++++++
 tb/tb_serial_adder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Digit-serial adder/subtractor, DIGIT bits per clock, LSB first,
//               valid/ready on both sides. SERIAL_ADDER_ZERO_FLAG_EN adds a
//               registered zero-result flag output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int c_NDIG  = WIDTH / DIGIT;
    localparam int c_CNT_W = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NDIG - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT:0]     w_dsum;
    logic [WIDTH-1:0]   w_digit_ext;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic               w_c_into_msb;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = reset_n;
                if (in_valid && reset_n) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_carry);
        // Carry into the digit MSB recovered from its sum bit: s = a ^ b ^ c.
        w_c_into_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];
        w_digit_ext  = '0;
        w_digit_ext[DIGIT-1:0] = w_dsum[DIGIT-1:0];
        w_sum_nxt    = (r_sum >> DIGIT) | (w_digit_ext << (WIDTH - DIGIT));
    end

`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    logic r_zero;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
            r_zero  <= 1'b0;
`endif
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1, so the operand is inverted once here.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_nxt;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_cout <= w_dsum[DIGIT];
                r_ovf  <= w_c_into_msb ^ w_dsum[DIGIT];
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
                r_zero <= (w_sum_nxt == '0);
`endif
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    assign zero     = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (8x1 and 32x4 instances)
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic       iv8, ir8, vld8, ordy8, cin8, sub8, co8, of8, z8;
    logic [7:0] a8, b8, s8;
    logic        iv32, ir32, vld32, ordy32, cin32, sub32, co32, of32, z32;
    logic [31:0] a32, b32, s32;

    int n_vec = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(vld8), .out_ready(ordy8), .sum(s8), .cout(co8), .overflow(of8)
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        , .zero(z8)
`endif
    );

    serial_adder #(.WIDTH(32), .DIGIT(4)) u_dut32 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(vld32), .out_ready(ordy32), .sum(s32), .cout(co32), .overflow(of32)
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        , .zero(z32)
`endif
    );

`ifndef SERIAL_ADDER_ZERO_FLAG_EN
    assign z8  = 1'b0;
    assign z32 = 1'b0;
`endif

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub,
                                  output logic [31:0] s, output logic co,
                                  output logic ov, output logic z);
        longint m, half, ua, ub, sa, sb, r, sr, ci;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        ci   = cin ? 1 : 0;
        if (sub) begin
            r  = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            r  = ua + ub + ci;
            sr = sa + sb + ci;
            co = (r >= m);
        end
        s  = 32'(((r % m) + m) % m);
        ov = (sr >= half) || (sr < -half);
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        z  = (s == 0);
`else
        z  = 1'b0;
`endif
    endfunction

    // Drives one full transaction; returns observed result and accept-to-valid latency.
    task automatic do_op(input bit big, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input int hold,
                         output logic [31:0] s, output logic co, output logic ov,
                         output logic z, output int lat);
        int n;
        @(negedge clock);
        if (big) begin
            a32 = a; b32 = b; cin32 = cin; sub32 = sub; iv32 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; iv8 = 1'b1;
        end
        n = 0;
        while (!(big ? ir32 : ir8) && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        iv8  = 1'b0;
        iv32 = 1'b0;
        lat  = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!(big ? vld32 : vld8) && lat < 100);
        s  = big ? s32 : {24'd0, s8};
        co = big ? co32 : co8;
        ov = big ? of32 : of8;
        z  = big ? z32 : z8;
        repeat (hold) @(negedge clock);
        @(negedge clock);
        ordy8  = 1'b1;
        ordy32 = 1'b1;
        @(posedge clock);
        #1;
        ordy8  = 1'b0;
        ordy32 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        n_vec++; if (ir8 !== 1'b0)   begin n_err++; $display("FAIL reset_in_ready8 got %b want 0", ir8); end
        n_vec++; if (ir32 !== 1'b0)  begin n_err++; $display("FAIL reset_in_ready32 got %b want 0", ir32); end
        n_vec++; if (vld8 !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got %b want 0", vld8); end
        n_vec++; if (s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0 || z8 !== 1'b0)
            begin n_err++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b z=%b want 00/0/0/0", s8, co8, of8, z8); end
        repeat (2) @(posedge clock);
        n_vec++; if (ir8 !== 1'b0)   begin n_err++; $display("FAIL reset_hold_in_ready got %b want 0", ir8); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_vec++; if (ir8 !== 1'b1 || ir32 !== 1'b1)
            begin n_err++; $display("FAIL release_in_ready got %b/%b want 1/1", ir8, ir32); end
    endtask

    task automatic check_result(input string name, input int exp_lat, input int lat,
                                input logic [31:0] s, input logic co, input logic ov, input logic z,
                                input logic [31:0] es, input logic eco, input logic eov, input logic ez);
        n_vec++;
        if (lat !== exp_lat || s !== es || co !== eco || ov !== eov || z !== ez) begin
            n_err++;
            $display("FAIL %s got lat=%0d sum=%h cout=%b ovf=%b z=%b want lat=%0d sum=%h cout=%b ovf=%b z=%b",
                     name, lat, s, co, ov, z, exp_lat, es, eco, eov, ez);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'h0F, 32'h7F, 32'hFF, 32'h05, 32'h80};
        logic [31:0] tb [5] = '{32'h01, 32'h01, 32'h01, 32'h07, 32'h01};
        logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] s, es;
        logic co, ov, z, eco, eov, ez;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, ta[i], tb[i], tc[i], ts[i], 0, s, co, ov, z, lat);
            model(8, ta[i], tb[i], tc[i], ts[i], es, eco, eov, ez);
            check_result($sformatf("directed8_%0d", i), 8, lat, s, co, ov, z, es, eco, eov, ez);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, s, es;
        logic cin, sub, co, ov, z, eco, eov, ez;
        int lat;
        for (int i = 0; i < 60; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            if (i % 10 == 0) b = a;
            do_op(i[0], a, b, cin, sub, 0, s, co, ov, z, lat);
            model(i[0] ? 32 : 8, a, b, cin, sub, es, eco, eov, ez);
            check_result(i[0] ? "random32" : "random8", 8, lat, s, co, ov, z, es, eco, eov, ez);
        end
    endtask

    task automatic test_wide_boundary();
        logic [31:0] s;
        logic co, ov, z;
        int lat;
        do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, s, co, ov, z, lat);
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        check_result("wide_wrap", 8, lat, s, co, ov, z, 32'h0, 1'b1, 1'b0, 1'b1);
`else
        check_result("wide_wrap", 8, lat, s, co, ov, z, 32'h0, 1'b1, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clock);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clock);
        #1;
        iv8 = 1'b0;
        n = 0;
        while (!vld8 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            n_vec++;
            if (vld8 !== 1'b1 || ir8 !== 1'b0 || s8 !== 8'h10 || co8 !== 1'b0 || of8 !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_hold cyc%0d got valid=%b ready=%b sum=%h cout=%b ovf=%b want 1/0/10/0/0",
                         i, vld8, ir8, s8, co8, of8);
            end
        end
        @(negedge clock);
        ordy8 = 1'b1;
        @(posedge clock);
        #1;
        ordy8 = 1'b0;
        iv8   = 1'b0;
        n_vec++;
        if (vld8 !== 1'b0 || ir8 !== 1'b1 || s8 !== 8'h10) begin
            n_err++;
            $display("FAIL backpressure_release got valid=%b ready=%b sum=%h want 0/1/10", vld8, ir8, s8);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, s, es;
        logic cin, sub, co, ov, z, eco, eov, ez;
        int lat;
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            do_op(1'b0, a, b, cin, sub, $urandom_range(0, 3), s, co, ov, z, lat);
            model(8, a, b, cin, sub, es, eco, eov, ez);
            check_result("back_to_back", 8, lat, s, co, ov, z, es, eco, eov, ez);
            n_vec++;
            if (ir8 !== 1'b1 || vld8 !== 1'b0 || s8 !== es[7:0]) begin
                n_err++;
                $display("FAIL bubble got ready=%b valid=%b sum=%h want 1/0/%h", ir8, vld8, s8, es[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        logic co, ov, z;
        int lat, n;
        bit seen;
        // Abort in RUN.
        @(negedge clock);
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clock);
        #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (vld8 !== 1'b0 || ir8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_run got valid=%b ready=%b sum=%h cout=%b ovf=%b want 0/0/00/0/0",
                     vld8, ir8, s8, co8, of8);
        end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (vld8 === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_no_valid got 1 want 0"); end
        do_op(1'b0, 32'h12, 32'h34, 1'b0, 1'b0, 0, s, co, ov, z, lat);
        check_result("after_reset", 8, lat, s, co, ov, z, 32'h46, 1'b0, 1'b0, 1'b0);
        // Abort in DONE with a non-zero result pending.
        @(negedge clock);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clock);
        #1;
        iv8 = 1'b0;
        n = 0;
        while (!vld8 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (vld8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_done got valid=%b sum=%h cout=%b ovf=%b want 0/00/0/0", vld8, s8, co8, of8);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        iv32 = 1'b0; ordy32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_wide_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
